alu_pipe: RTL

//   Registered, handshaked successor to the combinational alu: WIDTH-bit datapath,

---
 rtl/alu_pipe.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Registered, handshaked ALU: single-cycle logic/shift/add/sub ops plus an
// iterative unsigned shift-add multiply that holds off new work until done.

package alu_ops;
    typedef enum logic [3:0] {
        LL_SHIFT = 4'd0,
        LR_SHIFT = 4'd1,
        AL_SHIFT = 4'd2,
        AR_SHIFT = 4'd3,
        NOT      = 4'd4,
        AND      = 4'd5,
        OR       = 4'd6,
        XOR      = 4'd7,
        ADD      = 4'd8,
        SUB      = 4'd9,
        MUL_OP   = 4'd10
    } opcode_e;
endpackage

module alu_pipe
    import alu_ops::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             overflow,
    output logic             negative,
    output logic             zero,
    output logic             illegal
);

    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH:0] W_LIM = W1'(WIDTH);

    typedef enum logic {IDLE, MUL_BUSY} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [W2-1:0]     prod_q, prod_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              out_valid_d, cout_d, overflow_d, negative_d, zero_d, illegal_d;
    logic [WIDTH-1:0]  y_d;
    logic              accept, load;

    logic [WIDTH:0]    sum, diff;
    logic              big_shift;
    logic [WIDTH-1:0]  alu_y;
    logic              alu_cout, alu_ovf, alu_ill;

    logic [WIDTH:0]    mul_sum;
    logic [W2-1:0]     mul_next;

    assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath; MUL_OP is handled by the iterative unit below.
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b} + W1'(cin);
        diff      = {1'b0, a} - {1'b0, b} - W1'(cin);
        big_shift = ({1'b0, b} >= W_LIM);
        alu_y     = '0;
        alu_cout  = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        case (opcode)
            LL_SHIFT, AL_SHIFT: alu_y = big_shift ? '0 : (a << b);
            LR_SHIFT:           alu_y = big_shift ? '0 : (a >> b);
            AR_SHIFT:           alu_y = big_shift ? {WIDTH{a[WIDTH-1]}}
                                                  : WIDTH'($signed(a) >>> b);
            NOT:                alu_y = ~a;
            AND:                alu_y = a & b;
            OR:                 alu_y = a | b;
            XOR:                alu_y = a ^ b;
            ADD: begin
                alu_y    = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            SUB: begin
                alu_y    = diff[WIDTH-1:0];
                alu_cout = diff[WIDTH];
                alu_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            MUL_OP:             alu_y = '0;
            default:            alu_ill = 1'b1;
        endcase
    end

    // One shift-add step: conditionally add multiplicand to the high half, then shift right.
    always_comb begin
        mul_sum  = {1'b0, prod_q[W2-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : W1'(0));
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid && !out_ready;
        y_d         = y;
        cout_d      = cout;
        overflow_d  = overflow;
        illegal_d   = illegal;
        negative_d  = negative;
        zero_d      = zero;
        load        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (opcode == MUL_OP) begin
                        state_d = MUL_BUSY;
                        mcand_d = a;
                        prod_d  = {WIDTH'(0), b};
                        cnt_d   = '0;
                    end else begin
                        load       = 1'b1;
                        y_d        = alu_y;
                        cout_d     = alu_cout;
                        overflow_d = alu_ovf;
                        illegal_d  = alu_ill;
                    end
                end
            end
            MUL_BUSY: begin
                prod_d = mul_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d    = IDLE;
                    load       = 1'b1;
                    y_d        = mul_next[WIDTH-1:0];
                    cout_d     = |mul_next[W2-1:WIDTH];
                    overflow_d = 1'b0;
                    illegal_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            out_valid_d = 1'b1;
            negative_d  = y_d[WIDTH-1];
            zero_d      = (y_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            out_valid <= out_valid_d;
            y         <= y_d;
            cout      <= cout_d;
            overflow  <= overflow_d;
            negative  <= negative_d;
            zero      <= zero_d;
            illegal   <= illegal_d;
        end
    end

endmodule
